// File: rtl/row_payload_uart_tx.sv
// Serial row-payload source: latches a PAYLOAD_BYTES-wide row and sends it MSB byte first as 8N1 UART frames.
// Optional feature macro ROW_PAYLOAD_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module row_payload_uart_tx #(
  parameter int PAYLOAD_BYTES      = 4,
  parameter int UART_TICKS_PER_BIT = 22,
  parameter int GAP_TICKS          = 0,
  parameter int REPEAT_W           = 8
) (
  input  logic                                 clk_in,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [PAYLOAD_BYTES*8-1:0]           payload,
  input  logic [REPEAT_W-1:0]                  repeat_count,
  output logic                                 tx_out,
  output logic                                 busy,
  output logic                                 byte_strobe,
  output logic [$clog2(PAYLOAD_BYTES+2)-1:0]   byte_index,
  output logic                                 done
);
  localparam int IDXW  = $clog2(PAYLOAD_BYTES+2);
  localparam int TICKW = $clog2(UART_TICKS_PER_BIT);
  localparam int GAPW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
  localparam int LAST_IDX = PAYLOAD_BYTES;
`else
  localparam int LAST_IDX = PAYLOAD_BYTES - 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t                   r_state, w_next;
  logic [TICKW-1:0]         r_tick;
  logic [2:0]               r_bit;
  logic [GAPW-1:0]          r_gap;
  logic [PAYLOAD_BYTES*8-1:0] r_payload;
  logic [REPEAT_W-1:0]      r_repeat, r_frame;
  logic [IDXW-1:0]          r_idx;
  logic [7:0]               r_shift;
  logic                     r_done;
  logic                     w_tick_last, w_gap_last, w_last_byte, w_more_frames;
  logic [7:0]               w_byte;

  assign w_tick_last   = (r_tick == TICKW'(UART_TICKS_PER_BIT-1));
  assign w_gap_last    = (r_gap == GAPW'(GAP_TICKS-1));
  assign w_last_byte   = (r_idx == IDXW'(LAST_IDX));
  assign w_more_frames = (r_frame < r_repeat);

`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
  logic [7:0] w_csum;
  always_comb begin
    w_csum = 8'h00;
    for (int b = 0; b < PAYLOAD_BYTES; b++) w_csum ^= r_payload[8*b +: 8];
  end
`endif

  // byte_index 0 selects the most significant payload byte
  always_comb begin
    w_byte = 8'h00;
    for (int b = 0; b < PAYLOAD_BYTES; b++)
      if (r_idx == IDXW'(b)) w_byte = r_payload[8*(PAYLOAD_BYTES-1-b) +: 8];
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
    if (r_idx == IDXW'(PAYLOAD_BYTES)) w_byte = w_csum;
`endif
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_START;
      S_START: if (w_tick_last) w_next = S_DATA;
      S_DATA:  if (w_tick_last && r_bit == 3'd7) w_next = S_STOP;
      S_STOP:
        if (w_tick_last) begin
          if (!w_last_byte || w_more_frames) w_next = (GAP_TICKS == 0) ? S_START : S_GAP;
          else                               w_next = S_IDLE;
        end
      S_GAP:   if (w_gap_last) w_next = S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_out      = 1'b1;
    busy        = (r_state != S_IDLE);
    byte_strobe = (r_state == S_START) && (r_tick == '0);
    case (r_state)
      S_START: tx_out = 1'b0;
      S_DATA:  tx_out = r_shift[0];
      default: tx_out = 1'b1;
    endcase
  end

  assign byte_index = r_idx;
  assign done       = r_done;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_tick    <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_payload <= '0;
      r_repeat  <= '0;
      r_frame   <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tick <= ((r_state == S_START || r_state == S_DATA || r_state == S_STOP) && !w_tick_last)
                ? r_tick + 1'b1 : '0;
      r_gap  <= (r_state == S_GAP && !w_gap_last) ? r_gap + 1'b1 : '0;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_payload <= payload;
            r_repeat  <= repeat_count;
            r_frame   <= '0;
            r_idx     <= '0;
          end
        S_START:
          if (w_tick_last) begin
            r_shift <= w_byte;
            r_bit   <= 3'd0;
          end
        S_DATA:
          if (w_tick_last) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end
        S_STOP:
          if (w_tick_last) begin
            if (!w_last_byte) r_idx <= r_idx + 1'b1;
            else if (w_more_frames) begin
              r_frame <= r_frame + 1'b1;
              r_idx   <= '0;
            end else begin
              r_done <= 1'b1;
              r_idx  <= '0;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_row_payload_uart_tx.sv
// Bench for row_payload_uart_tx: two instances (no gap / 6-cycle gap) checked cycle by cycle against a
// line-waveform model built from the byte list, bit timing and gap rules.
module tb_row_payload_uart_tx;
  localparam int PB = 2;
  localparam int T  = 4;

  logic clk_in = 1'b0;
  logic reset;
  logic [1:0]       start_v, tx_v, busy_v, strb_v, done_v;
  logic [1:0][15:0] pay_v;
  logic [1:0][7:0]  rep_v;
  logic [1:0][1:0]  idx_v;

  int n_chk = 0;
  int n_pass = 0;

  bit exp_tx[$];
  bit exp_sb[$];
  int exp_ix[$];

  always #5 clk_in = ~clk_in;

  row_payload_uart_tx #(.PAYLOAD_BYTES(PB), .UART_TICKS_PER_BIT(T), .GAP_TICKS(0), .REPEAT_W(8)) dut0 (
    .clk_in(clk_in), .reset(reset), .start(start_v[0]), .payload(pay_v[0]), .repeat_count(rep_v[0]),
    .tx_out(tx_v[0]), .busy(busy_v[0]), .byte_strobe(strb_v[0]), .byte_index(idx_v[0]), .done(done_v[0]));

  row_payload_uart_tx #(.PAYLOAD_BYTES(PB), .UART_TICKS_PER_BIT(T), .GAP_TICKS(6), .REPEAT_W(8)) dut1 (
    .clk_in(clk_in), .reset(reset), .start(start_v[1]), .payload(pay_v[1]), .repeat_count(rep_v[1]),
    .tx_out(tx_v[1]), .busy(busy_v[1]), .byte_strobe(strb_v[1]), .byte_index(idx_v[1]), .done(done_v[1]));

  function automatic int gap_of(input int d);
    return (d == 1) ? 6 : 0;
  endfunction

  // Expected line waveform starting at the first start-bit cycle.
  task automatic build(input logic [15:0] p, input int rep, input int gap);
    logic [7:0] bq[$];
    int iq[$];
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
    logic [7:0] cs;
`endif
    exp_tx.delete(); exp_sb.delete(); exp_ix.delete();
    for (int f = 0; f <= rep; f++) begin
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
      cs = 8'h00;
`endif
      for (int b = 0; b < PB; b++) begin
        bq.push_back(p[8*(PB-1-b) +: 8]);
        iq.push_back(b);
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
        cs ^= p[8*(PB-1-b) +: 8];
`endif
      end
`ifdef ROW_PAYLOAD_TX_CHECKSUM_EN
      bq.push_back(cs);
      iq.push_back(PB);
`endif
    end
    for (int i = 0; i < bq.size(); i++) begin
      for (int k = 0; k < 10; k++) begin
        bit v;
        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bq[i][k-1];
        for (int j = 0; j < T; j++) begin
          exp_tx.push_back(v);
          exp_sb.push_back(k == 0 && j == 0);
          exp_ix.push_back(iq[i]);
        end
      end
      if (i != bq.size() - 1)
        for (int j = 0; j < gap; j++) begin
          exp_tx.push_back(1'b1); exp_sb.push_back(1'b0); exp_ix.push_back(-1);
        end
    end
  endtask

  // Starts one transfer and compares every cycle until the expected done cycle.
  task automatic run_xfer(input int d, input logic [15:0] p, input logic [7:0] rep, input int poke_t,
                          input string nm);
    int n;
    int b_tx, b_sb, b_ix, b_bz, b_dn;
    logic g_tx, g_sb, g_bz, g_dn;
    int g_ix, e_ix;
    bit e_tx, e_sb, e_bz, e_dn;
    build(p, int'(rep), gap_of(d));
    n = exp_tx.size();
    b_tx = -1; b_sb = -1; b_ix = -1; b_bz = -1; b_dn = -1;
    g_tx = 0; g_sb = 0; g_bz = 0; g_dn = 0; g_ix = 0; e_ix = 0;
    e_tx = 0; e_sb = 0; e_bz = 0; e_dn = 0;
    @(negedge clk_in);
    start_v[d] = 1'b1; pay_v[d] = p; rep_v[d] = rep;
    for (int t = 1; t <= n + 1; t++) begin
      bit xt, xs, xb, xd;
      @(negedge clk_in);
      xt = (t <= n) ? exp_tx[t-1] : 1'b1;
      xs = (t <= n) ? exp_sb[t-1] : 1'b0;
      xb = (t <= n);
      xd = (t == n + 1);
      if (tx_v[d] !== xt && b_tx < 0) begin b_tx = t; g_tx = tx_v[d]; e_tx = xt; end
      if (strb_v[d] !== xs && b_sb < 0) begin b_sb = t; g_sb = strb_v[d]; e_sb = xs; end
      if (busy_v[d] !== xb && b_bz < 0) begin b_bz = t; g_bz = busy_v[d]; e_bz = xb; end
      if (done_v[d] !== xd && b_dn < 0) begin b_dn = t; g_dn = done_v[d]; e_dn = xd; end
      if (t <= n && exp_ix[t-1] >= 0 && int'(idx_v[d]) != exp_ix[t-1] && b_ix < 0) begin
        b_ix = t; g_ix = int'(idx_v[d]); e_ix = exp_ix[t-1];
      end
      if (t == 1) start_v[d] = 1'b0;
      if (poke_t > 1 && t == poke_t) begin start_v[d] = 1'b1; pay_v[d] = 16'h0000; end
      if (poke_t > 1 && t == poke_t + 1) start_v[d] = 1'b0;
    end
    n_chk++; if (b_tx >= 0) $display("FAIL %s tx_out t=%0d got %b exp %b", nm, b_tx, g_tx, e_tx); else n_pass++;
    n_chk++; if (b_sb >= 0) $display("FAIL %s byte_strobe t=%0d got %b exp %b", nm, b_sb, g_sb, e_sb); else n_pass++;
    n_chk++; if (b_bz >= 0) $display("FAIL %s busy t=%0d got %b exp %b", nm, b_bz, g_bz, e_bz); else n_pass++;
    n_chk++; if (b_dn >= 0) $display("FAIL %s done t=%0d got %b exp %b", nm, b_dn, g_dn, e_dn); else n_pass++;
    n_chk++; if (b_ix >= 0) $display("FAIL %s byte_index t=%0d got %0d exp %0d", nm, b_ix, g_ix, e_ix); else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (tx_v[d] !== 1'b1) $display("FAIL reset_tx d%0d got %b exp 1", d, tx_v[d]); else n_pass++;
      n_chk++; if (busy_v[d] !== 1'b0) $display("FAIL reset_busy d%0d got %b exp 0", d, busy_v[d]); else n_pass++;
      n_chk++; if (strb_v[d] !== 1'b0) $display("FAIL reset_strobe d%0d got %b exp 0", d, strb_v[d]); else n_pass++;
      n_chk++; if (done_v[d] !== 1'b0) $display("FAIL reset_done d%0d got %b exp 0", d, done_v[d]); else n_pass++;
      n_chk++; if (idx_v[d] !== 2'd0) $display("FAIL reset_index d%0d got %0d exp 0", d, idx_v[d]); else n_pass++;
    end
  endtask

  task automatic test_basic();
    run_xfer(0, 16'hA55A, 8'd0, 0, "basic_a55a");
  endtask

  task automatic test_gap_repeat();
    run_xfer(1, 16'hA55A, 8'd2, 0, "gap_repeat");
  endtask

  task automatic test_ignored_start();
    run_xfer(0, 16'hA55A, 8'd0, 20, "ignored_start");
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk_in);
    start_v[0] = 1'b1; pay_v[0] = 16'hA55A; rep_v[0] = 8'd0;
    for (int t = 1; t < 30; t++) begin
      @(negedge clk_in);
      if (t == 1) start_v[0] = 1'b0;
    end
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    n_chk++; if (tx_v[0] !== 1'b1) $display("FAIL midreset_tx got %b exp 1", tx_v[0]); else n_pass++;
    n_chk++; if (busy_v[0] !== 1'b0) $display("FAIL midreset_busy got %b exp 0", busy_v[0]); else n_pass++;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    bad = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk_in);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL postreset_quiet bad_cycles got %0d exp 0", bad); else n_pass++;
    run_xfer(0, 16'hA55A, 8'd0, 0, "fresh_after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int d;
      logic [15:0] p;
      logic [7:0] r;
      d = k % 2;
      p = 16'($urandom);
      r = 8'($urandom_range(0, 2));
      run_xfer(d, p, r, 0, $sformatf("random%0d", k));
    end
  endtask

  task automatic test_back_to_back();
    int n, bad, seen;
    logic [15:0] p;
    p = 16'($urandom);
    build(p, 0, 0);
    n = exp_tx.size();
    bad = 0;
    @(negedge clk_in);
    start_v[0] = 1'b1; pay_v[0] = p; rep_v[0] = 8'd0;
    for (int t = 1; t <= n; t++) begin
      @(negedge clk_in);
      if (tx_v[0] !== exp_tx[t-1]) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL b2b_first_trace bad_cycles got %0d exp 0", bad); else n_pass++;
    @(negedge clk_in);
    n_chk++; if (done_v[0] !== 1'b1) $display("FAIL b2b_done got %b exp 1", done_v[0]); else n_pass++;
    n_chk++; if (tx_v[0] !== 1'b1) $display("FAIL b2b_idle_cycle_tx got %b exp 1", tx_v[0]); else n_pass++;
    @(negedge clk_in);
    n_chk++; if (tx_v[0] !== 1'b0) $display("FAIL b2b_next_start_tx got %b exp 0", tx_v[0]); else n_pass++;
    n_chk++; if (strb_v[0] !== 1'b1) $display("FAIL b2b_next_strobe got %b exp 1", strb_v[0]); else n_pass++;
    start_v[0] = 1'b0;
    seen = 0;
    for (int t = 2; t <= n + 1; t++) begin
      @(negedge clk_in);
      if (done_v[0] === 1'b1) seen = t;
    end
    n_chk++; if (seen != n + 1) $display("FAIL b2b_second_done cycle got %0d exp %0d", seen, n + 1); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start_v = '0; pay_v = '0; rep_v = '0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_gap_repeat();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
